// File: rtl/register_bank_pkg.sv
// Shared types and helpers for the SSM general-purpose register bank.
package register_bank_pkg;

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam int NUM_REGS_DEFAULT = 8;
  localparam int IDX_W            = $clog2(NUM_REGS_DEFAULT);

  // Power-on contents: each register holds its own index (caller truncates).
  function automatic logic [63:0] reg_reset_value(input int i);
    return 64'(i);
  endfunction

endpackage

// File: rtl/register_clear_seq.sv
// Bulk-clear sequencer: walks the bank one entry per cycle and reports busy.
module register_clear_seq
  import register_bank_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter int IDX_W    = register_bank_pkg::IDX_W
) (
  input  logic             register_clock,
  input  logic             register_reset,
  input  logic             clear_start,
  output logic             register_busy,
  output logic             clr_we,
  output logic [IDX_W-1:0] clr_idx
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             last;

  assign last = (idx == IDX_W'(NUM_REGS - 1));

  always_ff @(posedge register_clock) begin
    if (register_reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // clear_start is only honoured from IDLE; a pulse mid-sequence is ignored.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: if (clear_start) begin
        state_nxt = CLEAR;
        idx_nxt   = '0;
      end
      CLEAR: begin
        idx_nxt = idx + 1'b1;
        if (last) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  assign register_busy = (state == CLEAR);
  assign clr_we        = register_busy;
  assign clr_idx       = idx;

endmodule

// File: rtl/tri_state_buffer.sv
// Drives the shared system bus when enabled, otherwise releases it to high-Z.
module tri_state_buffer #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             enable,
  output wire  [WIDTH-1:0] data_out
);

  assign data_out = enable ? data_in : {WIDTH{1'bz}};

endmodule

// File: rtl/register_bank.sv
// Parametrised register bank: bus write/read port, two ALU read ports, sequenced clear.
// Build option REGISTER_BYPASS_EN forwards a same-cycle write to the read ports.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  register_clock,
  input  logic                  register_reset,
  input  logic [ADDR_WIDTH-1:0] register_addr,
  input  logic [DATA_WIDTH-1:0] bus_register_input,
  input  logic                  bus_register_input_en,
  input  logic                  bus_register_out_en,
  output wire  [DATA_WIDTH-1:0] bus_register_output,
  input  logic [ADDR_WIDTH-1:0] read_a_addr,
  output logic [DATA_WIDTH-1:0] read_a_data,
  input  logic [ADDR_WIDTH-1:0] read_b_addr,
  output logic [DATA_WIDTH-1:0] read_b_data,
  input  logic                  clear_start,
  output logic                  register_busy,
  output logic                  register_addr_error,
  output logic [NUM_REGS-1:0]   reg_valid
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  clr_we;
  logic [IW-1:0]         clr_idx;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] bus_rd_data;

  function automatic logic in_rng(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  register_clear_seq #(.NUM_REGS(NUM_REGS), .IDX_W(IW)) u_clear_seq (
    .register_clock (register_clock),
    .register_reset (register_reset),
    .clear_start    (clear_start),
    .register_busy  (register_busy),
    .clr_we         (clr_we),
    .clr_idx        (clr_idx)
  );

  // Writes are accepted only while idle; writes during a clear vanish without an error.
  assign wr_ok = bus_register_input_en && !register_busy && in_rng(register_addr);

  always_ff @(posedge register_clock) begin
    if (register_reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= DATA_WIDTH'(reg_reset_value(i));
      reg_valid <= '0;
    end else if (clr_we) begin
      regs[clr_idx]      <= '0;
      reg_valid[clr_idx] <= 1'b0;
    end else if (wr_ok) begin
      regs[register_addr[IW-1:0]]      <= bus_register_input;
      reg_valid[register_addr[IW-1:0]] <= 1'b1;
    end
  end

  always_ff @(posedge register_clock) begin
    if (register_reset)
      register_addr_error <= 1'b0;
    else
      register_addr_error <= bus_register_input_en && !register_busy && !in_rng(register_addr);
  end

  function automatic logic [DATA_WIDTH-1:0] rd(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    if (in_rng(a)) d = regs[a[IW-1:0]];
`ifdef REGISTER_BYPASS_EN
    if (wr_ok && (a == register_addr)) d = bus_register_input;
`endif
    return d;
  endfunction

  always_comb begin
    read_a_data = rd(read_a_addr);
    read_b_data = rd(read_b_addr);
    bus_rd_data = rd(register_addr);
  end

  tri_state_buffer #(.WIDTH(DATA_WIDTH)) u_bus_buf (
    .data_in  (bus_rd_data),
    .enable   (bus_register_out_en),
    .data_out (bus_register_output)
  );

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank (default 16x8, 6-bit addresses).
module tb_register_bank;

  localparam int DW = 16;
  localparam int NR = 8;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr, ra_addr, rb_addr;
  logic [DW-1:0] din;
  logic          din_en, out_en, clr;
  wire  [DW-1:0] bus;
  logic [DW-1:0] ra_data, rb_data;
  logic          busy, aerr;
  logic [NR-1:0] valid;

  // Bench keeps a known pattern on the bus whenever the DUT must be released.
  logic          tb_drv;
  assign bus = tb_drv ? 16'hA5A5 : 16'hzzzz;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  register_bank #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
    .register_clock        (clk),
    .register_reset        (rst),
    .register_addr         (addr),
    .bus_register_input    (din),
    .bus_register_input_en (din_en),
    .bus_register_out_en   (out_en),
    .bus_register_output   (bus),
    .read_a_addr           (ra_addr),
    .read_a_data           (ra_data),
    .read_b_addr           (rb_addr),
    .read_b_data           (rb_data),
    .clear_start           (clr),
    .register_busy         (busy),
    .register_addr_error   (aerr),
    .reg_valid             (valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr = a; din = d; din_en = 1'b1;
    tick();
    din_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; addr = '0; din = '0; din_en = 0; out_en = 0; clr = 0;
    ra_addr = '0; rb_addr = '0; tb_drv = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) begin
      ra_addr = AW'(i); exp_q.push_back(32'(i)); #1;
      e = exp_q.pop_front(); checks++;
      if (ra_data !== e[DW-1:0]) begin failures++; $display("FAIL reset_reg%0d got=%h exp=%h", i, ra_data, e[DW-1:0]); end
    end
    checks++; if (valid !== 8'h00) begin failures++; $display("FAIL reset_valid got=%h exp=00", valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (aerr !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", aerr); end
    checks++; if (bus !== 16'hA5A5) begin failures++; $display("FAIL reset_bus_released got=%h exp=a5a5", bus); end
  endtask

  task automatic test_write();
    write(6'd3, 16'hBEEF); exp_q.push_back(32'hBEEF); exp_q.push_back(32'hBEEF);
    ra_addr = 6'd3; #1;
    e = exp_q.pop_front(); checks++;
    if (ra_data !== e[DW-1:0]) begin failures++; $display("FAIL write_read_a got=%h exp=%h", ra_data, e[DW-1:0]); end
    checks++; if (valid !== 8'h08) begin failures++; $display("FAIL write_valid got=%h exp=08", valid); end
    tb_drv = 1'b0; out_en = 1'b1; addr = 6'd3; #1;
    e = exp_q.pop_front(); checks++;
    if (bus !== e[DW-1:0]) begin failures++; $display("FAIL write_bus got=%h exp=%h", bus, e[DW-1:0]); end
    out_en = 1'b0; #1; tb_drv = 1'b1;
  endtask

  task automatic test_out_of_range();
    write(6'd9, 16'h5555);
    rb_addr = 6'd9; exp_q.push_back(32'h0); #1;
    checks++; if (aerr !== 1'b1) begin failures++; $display("FAIL oor_err_pulse got=%b exp=1", aerr); end
    e = exp_q.pop_front(); checks++;
    if (rb_data !== e[DW-1:0]) begin failures++; $display("FAIL oor_read_b got=%h exp=%h", rb_data, e[DW-1:0]); end
    tick();
    checks++; if (aerr !== 1'b0) begin failures++; $display("FAIL oor_err_width got=%b exp=0", aerr); end
    checks++; if (valid !== 8'h08) begin failures++; $display("FAIL oor_valid got=%h exp=08", valid); end
    for (int i = 0; i < NR; i++) begin
      ra_addr = AW'(i); exp_q.push_back((i == 3) ? 32'hBEEF : 32'(i)); #1;
      e = exp_q.pop_front(); checks++;
      if (ra_data !== e[DW-1:0]) begin failures++; $display("FAIL oor_reg%0d got=%h exp=%h", i, ra_data, e[DW-1:0]); end
    end
  endtask

  task automatic test_clear();
    int cnt; logic saw_err;
    write(6'd5, 16'h7777);
    clr = 1'b1; tick(); clr = 1'b0;
    cnt = 0; saw_err = 0;
    for (int k = 0; k < 20 && busy; k++) begin
      cnt++;
      if (cnt == 5) write(6'd1, 16'h1111); else tick();
      if (aerr) saw_err = 1;
    end
    exp_q.push_back(32'(NR));
    e = exp_q.pop_front(); checks++;
    if (cnt !== int'(e)) begin failures++; $display("FAIL clear_busy_cycles got=%0d exp=%0d", cnt, e); end
    checks++; if (saw_err !== 1'b0) begin failures++; $display("FAIL clear_busy_write_err got=%b exp=0", saw_err); end
    checks++; if (valid !== 8'h00) begin failures++; $display("FAIL clear_valid got=%h exp=00", valid); end
    for (int i = 0; i < NR; i++) begin
      ra_addr = AW'(i); exp_q.push_back(32'h0); #1;
      e = exp_q.pop_front(); checks++;
      if (ra_data !== e[DW-1:0]) begin failures++; $display("FAIL clear_reg%0d got=%h exp=%h", i, ra_data, e[DW-1:0]); end
    end
  endtask

  task automatic test_reset_mid_clear();
    write(6'd4, 16'h4444);
    clr = 1'b1; tick(); clr = 1'b0;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (valid !== 8'h00) begin failures++; $display("FAIL midrst_valid got=%h exp=00", valid); end
    for (int i = 0; i < NR; i++) begin
      rb_addr = AW'(i); exp_q.push_back(32'(i)); #1;
      e = exp_q.pop_front(); checks++;
      if (rb_data !== e[DW-1:0]) begin failures++; $display("FAIL midrst_reg%0d got=%h exp=%h", i, rb_data, e[DW-1:0]); end
    end
  endtask

  task automatic test_bypass();
    addr = 6'd2; din = 16'h1234; din_en = 1'b1; ra_addr = 6'd2;
`ifdef REGISTER_BYPASS_EN
    exp_q.push_back(32'h1234);
`else
    exp_q.push_back(32'h0002);
`endif
    #1;
    e = exp_q.pop_front(); checks++;
    if (ra_data !== e[DW-1:0]) begin failures++; $display("FAIL same_cycle_read got=%h exp=%h", ra_data, e[DW-1:0]); end
    tick(); din_en = 1'b0;
    exp_q.push_back(32'h1234); #1;
    e = exp_q.pop_front(); checks++;
    if (ra_data !== e[DW-1:0]) begin failures++; $display("FAIL post_write_read got=%h exp=%h", ra_data, e[DW-1:0]); end
  endtask

  task automatic test_back_to_back();
    int cnt;
    // Write and clear_start together: write lands first, the clear wipes it later.
    addr = 6'd6; din = 16'h6666; din_en = 1'b1; clr = 1'b1;
    tick(); din_en = 1'b0; clr = 1'b0;
    checks++; if (valid !== 8'h44) begin failures++; $display("FAIL b2b_valid got=%h exp=44", valid); end
    cnt = 0;
    for (int k = 0; k < 20 && busy; k++) begin
      cnt++;
      clr = (cnt == 4);
      tick();
      clr = 1'b0;
    end
    exp_q.push_back(32'(NR));
    e = exp_q.pop_front(); checks++;
    if (cnt !== int'(e)) begin failures++; $display("FAIL b2b_busy_cycles got=%0d exp=%0d", cnt, e); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_restart got=%b exp=0", busy); end
    ra_addr = 6'd6; rb_addr = 6'd2; #1;
    checks++; if (ra_data !== 16'h0) begin failures++; $display("FAIL b2b_reg6 got=%h exp=0000", ra_data); end
    checks++; if (rb_data !== 16'h0) begin failures++; $display("FAIL b2b_reg2 got=%h exp=0000", rb_data); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_out_of_range();
    test_clear();
    test_reset_mid_clear();
    test_bypass();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
